// File: rtl/phy_tx_lane_scheduler.sv
// Round-robin scheduler sharing one PHY TX byte path among four lane sources,
// with a COM training burst after reset and periodic SKP ordered-set insertion.
module phy_tx_lane_scheduler #(
   parameter int          INIT_COMS    = 4,
   parameter int          SKP_INTERVAL = 16,
   parameter logic [7:0]  COM_SYM      = 8'hBC,
   parameter logic [7:0]  SKP_SYM      = 8'h1C
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in0,
   input  logic [7:0] in1,
   input  logic [7:0] in2,
   input  logic [7:0] in3,
   input  logic [3:0] valid,
   output logic [3:0] ready,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       k_out,
   output logic [1:0] lane_out
);

   typedef enum logic [1:0] {INIT, ACTIVE, SKP} state_t;

   localparam logic [15:0] INIT_LAST = 16'(INIT_COMS - 1);
   localparam logic [15:0] SKP_LAST  = 16'(SKP_INTERVAL - 1);

   state_t      state;
   logic [15:0] init_cnt;
   logic [15:0] skp_cnt;
   logic [1:0]  skp_idx;
   logic [1:0]  rr_ptr;

   logic [3:0]  grant;
   logic [1:0]  gnt_lane;
   logic        gnt_any;
   logic [1:0]  idx;
   logic [7:0]  lane_data;
   logic        preempt;

   assign preempt = (skp_cnt == SKP_LAST);

   // Search starts at rr_ptr so the lane after the last winner has top priority.
   always_comb begin
      grant    = 4'b0000;
      gnt_lane = 2'd0;
      gnt_any  = 1'b0;
      idx      = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_ptr + 2'(k);
         if (!gnt_any && valid[idx]) begin
            gnt_any     = 1'b1;
            gnt_lane    = idx;
            grant[idx]  = 1'b1;
         end
      end
   end

   always_comb begin
      case (gnt_lane)
         2'd0:    lane_data = in0;
         2'd1:    lane_data = in1;
         2'd2:    lane_data = in2;
         default: lane_data = in3;
      endcase
   end

   // SKP preemption masks every grant, so no lane sees a handshake it cannot complete.
   assign ready = (state == ACTIVE && !preempt) ? grant : 4'b0000;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= INIT;
         init_cnt  <= 16'd0;
         skp_cnt   <= 16'd0;
         skp_idx   <= 2'd0;
         rr_ptr    <= 2'd0;
         data_out  <= 8'd0;
         valid_out <= 1'b0;
         k_out     <= 1'b0;
         lane_out  <= 2'd0;
      end else begin
         case (state)
            INIT: begin
               data_out  <= COM_SYM;
               k_out     <= 1'b1;
               valid_out <= 1'b1;
               lane_out  <= 2'd0;
               init_cnt  <= init_cnt + 16'd1;
               if (init_cnt == INIT_LAST) begin
                  state   <= ACTIVE;
                  skp_cnt <= 16'd0;
               end
            end

            ACTIVE: begin
               if (preempt) begin
                  data_out  <= COM_SYM;
                  k_out     <= 1'b1;
                  valid_out <= 1'b1;
                  lane_out  <= 2'd0;
                  state     <= SKP;
                  skp_idx   <= 2'd0;
                  skp_cnt   <= 16'd0;
               end else begin
                  skp_cnt <= skp_cnt + 16'd1;
                  if (gnt_any) begin
                     data_out  <= lane_data;
                     k_out     <= 1'b0;
                     valid_out <= 1'b1;
                     lane_out  <= gnt_lane;
                     rr_ptr    <= gnt_lane + 2'd1;
                  end else begin
                     data_out  <= 8'd0;
                     k_out     <= 1'b0;
                     valid_out <= 1'b0;
                     lane_out  <= 2'd0;
                  end
               end
            end

            SKP: begin
               data_out  <= SKP_SYM;
               k_out     <= 1'b1;
               valid_out <= 1'b1;
               lane_out  <= 2'd0;
               skp_idx   <= skp_idx + 2'd1;
               if (skp_idx == 2'd2) state <= ACTIVE;
            end

            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: doc/phy_tx_lane_scheduler.md
Name: phy_tx_lane_scheduler

Overview:
Round-robin scheduler that shares the single PHY TX byte path between the four 8-bit lane sources (in0..in3), using per-lane valid/ready handshakes.
- After reset it emits a COM training burst.
- During operation it periodically preempts all lanes to insert a SKP ordered set (COM + 3×SKP).
- It sits in front of the TX byte-striping/encoding stage. It tags each byte as data or K-symbol and records the source lane.

Parameters:
INIT_COMS, 4, number of COM symbols emitted after reset release before data is accepted (1..65535)
SKP_INTERVAL, 16, ACTIVE cycles between SKP ordered sets, including the preempt cycle (2..65535)
COM_SYM, 8'hBC, comma K-symbol value
SKP_SYM, 8'h1C, skip K-symbol value

Ports:
clk  input  1  single system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset
in0  input  8  lane 0 data, sampled only on handshake
in1  input  8  lane 1 data
in2  input  8  lane 2 data
in3  input  8  lane 3 data
valid  input  4  per-lane request, bit i for in<i>
ready  output  4  one-hot grant, combinational from state/valid/rr pointer; handshake = valid[i]&ready[i]
data_out  output  8  registered TX byte
valid_out  output  1  registered; 1 when data_out carries a data byte or K-symbol
k_out  output  1  registered; 1 when data_out is a K-symbol (COM/SKP)
lane_out  output  2  registered source lane of data byte; 0 for K-symbols/idle

Behaviour:
- Reset (reset=0, asynchronous):
  - data_out=0, valid_out=0, k_out=0, lane_out=0, ready=0.
  - State=INIT, init_cnt=0, skp_cnt=0, skp_idx=0, rr_ptr=0.
  - Reset asserted mid-operation (any state) clears immediately; after release the block restarts from INIT.
- States: INIT, ACTIVE, SKP. Counters are 16-bit.
- INIT:
  - ready=0.
  - Each edge registers data_out=COM_SYM, k_out=1, valid_out=1, lane_out=0, and increments init_cnt.
  - At the edge where init_cnt==INIT_COMS-1, next state=ACTIVE and skp_cnt=0.
  - Exactly INIT_COMS COMs are emitted.
- ACTIVE, skp_cnt < SKP_INTERVAL-1:
  - Arbitration: search lanes rr_ptr, rr_ptr+1, ... (mod 4); grant the first with valid=1; ready = one-hot of that lane.
  - Grant to lane i: next edge registers data_out=in<i>, k_out=0, valid_out=1, lane_out=i; rr_ptr=(i+1) mod 4.
  - No valid lane: ready=0; registers data_out=0, valid_out=0, k_out=0, lane_out=0; rr_ptr unchanged.
  - skp_cnt increments every ACTIVE cycle, whether or not a grant occurs.
- ACTIVE, skp_cnt == SKP_INTERVAL-1 (preempt cycle):
  - ready=0 regardless of valid; SKP insertion has priority over any grant.
  - The edge registers COM_SYM with k_out=1, valid_out=1; next state=SKP, skp_idx=0, skp_cnt=0.
- SKP:
  - ready=0.
  - Each edge registers SKP_SYM, k_out=1, valid_out=1, and increments skp_idx.
  - At skp_idx==2, next state=ACTIVE.
  - rr_ptr is preserved across SKP.
- Latency: handshake cycle N → byte on data_out after edge N (1 clk).
- Lanes not granted must hold their data; no data is dropped or duplicated.
- Output stream period while fully loaded: SKP_INTERVAL-1 data bytes, then BC,1C,1C,1C.
- valid/in changes while ready=0 have no effect.

Test Plan:
- Reset low 6 clks, release; INIT_COMS=4 → 4 cycles data_out=BC, k_out=1, valid_out=1, ready=0; ready goes active the next cycle.
- All valid=4'b1111, in0..3=FF,EE,DD,CC → data_out FF,EE,DD,CC,FF..., lane_out 0,1,2,3,0, k_out=0.
- valid=4'b0100 constant, in2=99 → ready=4'b0100 every non-SKP cycle; data_out=99, lane_out=2. Then valid=4'b0101 → alternating lane 0/lane 2 grants, starting with lane 0 (rr_ptr=3 wraps to 0).
- Fully loaded, SKP_INTERVAL=16 → 15 data bytes, preempt cycle ready=0, then BC,1C,1C,1C with k_out=1. Data resumes at the lane following the last grant; no byte lost (check sequence continuity).
- valid=0 in ACTIVE → data_out=00, valid_out=0, k_out=0, rr_ptr held; skp_cnt still advances, so SKP is still inserted on schedule.
- Assert reset during the 2nd SKP symbol → outputs 0 immediately (asynchronously). After release → 4 COMs, rr_ptr=0, lane 0 granted first.
